// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU result stage: result width, writeback FSM
// state encoding and the 3-bit branch condition codes.
package alu_stage_pkg;

  localparam int DATA_W = 16;

  // Writeback holding FSM: IDLE = no result held, HOLD = result awaiting
  // acceptance by the register-file write port.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } stage_state_e;

  // Branch condition codes.
  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_ALWAYS = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_NZ     = 3'b011;
  localparam logic [2:0] COND_N      = 3'b100;
  localparam logic [2:0] COND_NN     = 3'b101;
  localparam logic [2:0] COND_C      = 3'b110;
  localparam logic [2:0] COND_NC     = 3'b111;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus bundle between the control unit / ALU / register file and the ALU
// result stage.
//   master : drives the ALU result, flags, strobes and writeback ready;
//            observes held result, flag register, WBValid, BranchTaken,
//            Overrun.
//   slave  : the result stage itself (mirror directions).
interface alu_result_stage_if;
  import alu_stage_pkg::*;

  logic [DATA_W-1:0] input_ALU;
  logic              input_Zero;
  logic              input_Negative;
  logic              input_Carry;
  logic              input_Valid;
  logic              input_FlagWrite;
  logic              input_BranchEval;
  logic [2:0]        input_BranchCond;
  logic              input_WBReady;

  logic [DATA_W-1:0] output_ALUOut;
  logic              output_FlagZ;
  logic              output_FlagN;
  logic              output_FlagC;
  logic              output_WBValid;
  logic              output_BranchTaken;
  logic              output_Overrun;

  modport master (
    output input_ALU, input_Zero, input_Negative, input_Carry,
    output input_Valid, input_FlagWrite, input_BranchEval, input_BranchCond,
    output input_WBReady,
    input  output_ALUOut, output_FlagZ, output_FlagN, output_FlagC,
    input  output_WBValid, output_BranchTaken, output_Overrun
  );

  modport slave (
    input  input_ALU, input_Zero, input_Negative, input_Carry,
    input  input_Valid, input_FlagWrite, input_BranchEval, input_BranchCond,
    input  input_WBReady,
    output output_ALUOut, output_FlagZ, output_FlagN, output_FlagC,
    output output_WBValid, output_BranchTaken, output_Overrun
  );

endinterface

// File: rtl/alu_result_stage_branch_cond_eval.sv
// Combinational branch condition evaluator.
//   flag_z_i, flag_n_i, flag_c_i : flag values to test (already forwarded)
//   cond_i                       : 3-bit condition code
//   taken_o                      : 1 when the condition holds
module branch_cond_eval
  import alu_stage_pkg::*;
(
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  input  logic       flag_c_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_NEVER:  taken_o = 1'b0;
      COND_ALWAYS: taken_o = 1'b1;
      COND_Z:      taken_o = flag_z_i;
      COND_NZ:     taken_o = ~flag_z_i;
      COND_N:      taken_o = flag_n_i;
      COND_NN:     taken_o = ~flag_n_i;
      COND_C:      taken_o = flag_c_i;
      COND_NC:     taken_o = ~flag_c_i;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: holds the ALU result until the register file accepts
// it, maintains the architectural Z/N/C flag register and produces a
// registered branch decision.
//   input_CLK   : clock, all state updates on rising edge
//   input_Reset : synchronous active-high reset
//   bus (slave) : ALU result/flags, Valid/FlagWrite strobes, branch
//                 evaluation request, WBReady; outputs held result, flags,
//                 WBValid, BranchTaken and sticky Overrun.
// All outputs come straight from registers.
module alu_result_stage
  import alu_stage_pkg::*;
(
  input  logic                input_CLK,
  input  logic                input_Reset,
  alu_result_stage_if.slave   bus
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              fz_q, fz_d;
  logic              fn_q, fn_d;
  logic              fc_q, fc_d;
  logic              taken_q, taken_d;
  logic              ovr_q, ovr_d;
  logic              flag_load;
  logic              cond_taken;

  // Writeback FSM and result register. The result bus is only ever
  // steered into alu_d; no control decision looks at its value.
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.input_Valid) begin
          alu_d   = bus.input_ALU;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.input_WBReady) begin
          // Writeback completes; a simultaneous new result refills the
          // holding register with no bubble.
          if (bus.input_Valid) begin
            alu_d = bus.input_ALU;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.input_Valid) begin
          // Holding register busy: new result is dropped, flag it.
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag register update. The next-state values double as the forwarded
  // flags for branch evaluation, so a same-cycle flag write is seen.
  assign flag_load = bus.input_Valid & bus.input_FlagWrite;

  always_comb begin
    fz_d = fz_q;
    fn_d = fn_q;
    fc_d = fc_q;
    if (flag_load) begin
      fz_d = bus.input_Zero;
      fn_d = bus.input_Negative;
      fc_d = bus.input_Carry;
    end
  end

  branch_cond_eval u_cond (
    .flag_z_i (fz_d),
    .flag_n_i (fn_d),
    .flag_c_i (fc_d),
    .cond_i   (bus.input_BranchCond),
    .taken_o  (cond_taken)
  );

  always_comb begin
    taken_d = taken_q;
    if (bus.input_BranchEval) begin
      taken_d = cond_taken;
    end
  end

  always_ff @(posedge input_CLK) begin
    if (input_Reset) begin
      state_q <= ST_IDLE;
      alu_q   <= '0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
      fc_q    <= 1'b0;
      taken_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
      fc_q    <= fc_d;
      taken_q <= taken_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.output_ALUOut      = alu_q;
  assign bus.output_FlagZ       = fz_q;
  assign bus.output_FlagN       = fn_q;
  assign bus.output_FlagC       = fc_q;
  assign bus.output_WBValid     = (state_q == ST_HOLD);
  assign bus.output_BranchTaken = taken_q;
  assign bus.output_Overrun     = ovr_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage: a table of per-cycle input
// records with expected outputs, followed by hand-written sequences for the
// sticky overrun and the full condition-code sweep.
module tb_alu_result_stage;

  logic clk;
  logic rst;

  alu_result_stage_if bus_if ();

  alu_result_stage dut (
    .input_CLK   (clk),
    .input_Reset (rst),
    .bus         (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] alu;
    logic        z, n, c;
    logic        vld, fw, be;
    logic [2:0]  cond;
    logic        wbr;
    logic [21:0] exp; // {ALUOut, Z, N, C, WBValid, Taken, Overrun}
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int n_applied;
  int n_fail;

  function automatic vec_t mk(logic r, logic [15:0] a, logic z, logic n,
                              logic c, logic v, logic f, logic b,
                              logic [2:0] cd, logic w, logic [15:0] ea,
                              logic ez, logic en, logic ec, logic ewb,
                              logic etk, logic eov);
    vec_t t;
    t.rst = r; t.alu = a; t.z = z; t.n = n; t.c = c;
    t.vld = v; t.fw = f; t.be = b; t.cond = cd; t.wbr = w;
    t.exp = {ea, ez, en, ec, ewb, etk, eov};
    return t;
  endfunction

  task automatic drive(vec_t t);
    rst                     = t.rst;
    bus_if.input_ALU        = t.alu;
    bus_if.input_Zero       = t.z;
    bus_if.input_Negative   = t.n;
    bus_if.input_Carry      = t.c;
    bus_if.input_Valid      = t.vld;
    bus_if.input_FlagWrite  = t.fw;
    bus_if.input_BranchEval = t.be;
    bus_if.input_BranchCond = t.cond;
    bus_if.input_WBReady    = t.wbr;
  endtask

  function automatic logic [21:0] outs();
    return {bus_if.output_ALUOut, bus_if.output_FlagZ, bus_if.output_FlagN,
            bus_if.output_FlagC, bus_if.output_WBValid,
            bus_if.output_BranchTaken, bus_if.output_Overrun};
  endfunction

  task automatic check(string name, logic [21:0] act, logic [21:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, sample 1 time unit later.
  task automatic step(vec_t t);
    drive(t);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pattern;
  vec_t       idle;

  initial begin
    n_applied = 0;
    n_fail    = 0;
    //              rst alu      z n c v f b cond   w  expALU   Z N C WB T O
    vecs[0]  = mk(1, 16'h0000, 0,0,0, 0,0,0,3'b000,0, 16'h0000,0,0,0,0,0,0);
    vecs[1]  = mk(0, 16'h1234, 0,0,1, 1,1,0,3'b000,0, 16'h1234,0,0,1,1,0,0);
    vecs[2]  = mk(0, 16'h0000, 0,0,0, 0,0,0,3'b000,1, 16'h1234,0,0,1,0,0,0);
    vecs[3]  = mk(0, 16'h0001, 0,0,0, 1,0,0,3'b000,0, 16'h0001,0,0,1,1,0,0);
    vecs[4]  = mk(0, 16'h0002, 0,0,0, 1,0,0,3'b000,1, 16'h0002,0,0,1,1,0,0);
    vecs[5]  = mk(0, 16'h0000, 0,0,0, 0,0,0,3'b000,1, 16'h0002,0,0,1,0,0,0);
    vecs[6]  = mk(0, 16'h1111, 0,1,0, 1,1,0,3'b000,0, 16'h1111,0,1,0,1,0,0);
    // dropped result still loads flags
    vecs[7]  = mk(0, 16'h00FF, 1,0,0, 1,1,0,3'b000,0, 16'h1111,1,0,0,1,0,1);
    // FlagWrite without Valid ignored
    vecs[8]  = mk(0, 16'h0000, 0,1,1, 0,1,0,3'b000,0, 16'h1111,1,0,0,1,0,1);
    vecs[9]  = mk(0, 16'h0000, 0,0,0, 0,0,1,3'b010,0, 16'h1111,1,0,0,1,1,1);
    vecs[10] = mk(0, 16'h0000, 0,0,0, 0,0,0,3'b000,0, 16'h1111,1,0,0,1,1,1);
    // reset mid-HOLD overrides everything
    vecs[11] = mk(1, 16'hBEEF, 1,1,1, 1,1,1,3'b001,0, 16'h0000,0,0,0,0,0,0);
    vecs[12] = mk(0, 16'h0000, 0,0,0, 0,0,0,3'b000,0, 16'h0000,0,0,0,0,0,0);
    // forwarded Z (stale Z=0) in the same cycle as the flag write
    vecs[13] = mk(0, 16'h0042, 1,0,0, 1,1,1,3'b010,0, 16'h0042,1,0,0,1,1,0);
    vecs[14] = mk(0, 16'h0000, 0,0,0, 0,0,1,3'b011,1, 16'h0042,1,0,0,0,0,0);

    idle = mk(0, 16'h0000, 0,0,0, 0,0,0,3'b000,0, 22'h0 >> 6, 0,0,0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i]);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Sticky overrun: capture 00AA, drop 00FF, then 10 quiet cycles.
    begin
      vec_t t;
      t = idle; t.rst = 1'b1; step(t);
      t = idle; t.vld = 1'b1; t.alu = 16'h00AA; step(t);
      t = idle; t.vld = 1'b1; t.alu = 16'h00FF; step(t);
      check("ovr_aluout", {6'd0, bus_if.output_ALUOut}, {6'd0, 16'h00AA});
      check("ovr_set", {21'd0, bus_if.output_Overrun}, 22'd1);
      for (int k = 0; k < 10; k++) begin
        t = idle; t.wbr = 1'b1; step(t);
        check($sformatf("ovr_hold%0d", k), {21'd0, bus_if.output_Overrun}, 22'd1);
      end
      check("ovr_idle_wbv", {21'd0, bus_if.output_WBValid}, 22'd0);
    end

    // Condition sweep against Z=1 N=0 C=1.
    begin
      vec_t t;
      pattern = 8'b0110_0110; // bit i = expected taken for code i
      t = idle; t.vld = 1'b1; t.fw = 1'b1; t.z = 1'b1; t.c = 1'b1; step(t);
      t = idle; t.wbr = 1'b1; step(t);
      for (int k = 0; k < 8; k++) begin
        t = idle; t.be = 1'b1; t.cond = 3'(k); step(t);
        check($sformatf("cond%0d", k), {21'd0, bus_if.output_BranchTaken},
              {21'd0, pattern[k]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, applied %0d", n_applied);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have ports: input_CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: input_Reset  in  1  synchronous, active-high reset, sampled on rising input_CLK.
REQ-003 SHALL have: input_ALU  in  16  ALU result bus from the ALU.
REQ-004 SHALL have: input_Zero, input_Negative, input_Carry  in  1 each  ALU flags for input_ALU.
REQ-005 SHALL have: input_Valid  in  1  control unit asserts for one cycle when input_ALU/flags are final.
REQ-006 SHALL have: input_FlagWrite  in  1  qualifies input_Valid; updates the flag register.
REQ-007 SHALL have: input_BranchEval  in  1  strobe requesting a branch decision.
REQ-008 SHALL have: input_BranchCond  in  3  condition code for the evaluation.
REQ-009 SHALL have: input_WBReady  in  1  register-file write port accepts the held result.
REQ-010 SHALL have: output_ALUOut  out  16  held result (ALUOut register).
REQ-011 SHALL have: output_FlagZ, output_FlagN, output_FlagC  out  1 each  architectural flag register.
REQ-012 SHALL have: output_WBValid  out  1  held result awaiting writeback.
REQ-013 SHALL have: output_BranchTaken  out  1  registered branch decision.
REQ-014 SHALL have: output_Overrun  out  1  sticky; a valid result was dropped.

Function
REQ-015 SHALL implement FSM states IDLE and HOLD; output_WBValid = 1 exactly in HOLD.
REQ-016 IDLE + input_Valid SHALL capture input_ALU into output_ALUOut and enter HOLD next cycle.
REQ-017 HOLD + input_WBReady SHALL complete writeback; return to IDLE, or, if input_Valid in the same cycle, capture the new result and stay in HOLD (back-to-back, no bubble).
REQ-018 HOLD + !input_WBReady + input_Valid SHALL keep output_ALUOut unchanged, drop the new result, and set output_Overrun.
REQ-019 output_Overrun SHALL remain set until reset.
REQ-020 input_Valid && input_FlagWrite SHALL load Z/N/C from the inputs in the same edge, even when the result itself is dropped under REQ-018.
REQ-021 input_FlagWrite without input_Valid SHALL be ignored.
REQ-022 input_BranchEval SHALL set output_BranchTaken on the next edge; output_BranchTaken SHALL be held until the next input_BranchEval.
REQ-023 Condition codes: 000 never, 001 always, 010 Z, 011 !Z, 100 N, 101 !N, 110 C, 111 !C.
REQ-024 Evaluation and flag update in the same cycle SHALL use the incoming flags (forwarded), not the stale register.
REQ-025 Latency: capture-to-output_WBValid is 1 cycle; eval-to-output_BranchTaken is 1 cycle; there is no combinational path from inputs to any output.
REQ-026 An X on input_ALU SHALL be captured as-is; control and flag state SHALL never depend on it.

Reset
REQ-027 input_Reset SHALL force IDLE, output_ALUOut = 16'h0000, all three flags = 0, output_WBValid = 0, output_BranchTaken = 0, and output_Overrun = 0.
REQ-028 Reset SHALL override every simultaneous input, including mid-HOLD.
REQ-029 Results held at reset SHALL be discarded, with no writeback.

Structure
REQ-030 Shared package alu_stage_pkg SHALL hold the condition-code constants (REQ-023) and the FSM state encoding.
REQ-031 SHALL instantiate one combinational sub-module, branch_cond_eval (flags + code -> taken).
REQ-032 Implementation SHALL fall within 120-400 RTL lines.

Verification
REQ-033 Scenario 1: reset asserted mid-HOLD with input_ALU = 16'hBEEF -> next cycle all outputs 0 and state IDLE.
REQ-034 Scenario 2: input_Valid with 16'h1234, FlagWrite=1, Z=0 N=0 C=1, WBReady=1 next cycle -> output_ALUOut = 16'h1234, output_WBValid high for exactly 1 cycle, output_FlagC = 1.
REQ-035 Scenario 3: back-to-back Valid 16'h0001, then 16'h0002 with WBReady=1 -> output_WBValid stays high and output_ALUOut steps 0001 -> 0002 with no bubble.
REQ-036 Scenario 4: HOLD with WBReady=0 and Valid 16'h00FF arriving -> output_ALUOut unchanged, output_Overrun = 1 and still set 10 cycles later.
REQ-037 Scenario 5: same cycle Valid+FlagWrite with Z=1 and BranchEval code 010, previous Z=0 -> output_BranchTaken = 1 next cycle.
REQ-038 Scenario 6: all eight codes swept against flags Z=1 N=0 C=1 -> taken pattern 0,1,1,0,0,1,1,0.
